instruction_fetch_pipe: RTL and testbench
=========================================

# instruction_fetch_pipe

- Pipelined instruction-fetch stage directly upstream of the ID stage.
- Owns the PC register and issues in-order requests to instruction memory over a request/response handshake.
- Buffers returned instruction words and drives the IF/ID pipeline register (`instruction_IFID`, `pc_IFID`, `pc_4_IFID`) consumed by decode.
- Handles stalls from hazard detection, and flushes/redirects from the EX-stage branch/jump adder.

## Interface
Parameters:
- `WIDTH`, 32, datapath/address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `MAX_OUTSTANDING`, 2, fetch buffer depth (credits) when the buffer feature is compiled in; must be ≥2.

Ports:
- `clk`  in  1  single clock; all state on posedge.
- `reset`  in  1  synchronous, active-low: `reset==0` at a posedge resets all state.
- `stall`  in  1  hold IF/ID register contents (hazard unit).
- `flush`  in  1  squash IF/ID to a bubble at next edge.
- `redirect_en`  in  1  load `redirect_pc` into PC and discard all in-flight/buffered fetches.
- `redirect_pc`  in  WIDTH  branch/jump target from EX.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  WIDTH  fetch address (= PC).
- `imem_ready`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  response word valid; responses in request order, ≥1 cycle after acceptance.
- `imem_rdata`  in  WIDTH  instruction word.
- `instruction_IFID`  out  WIDTH  instruction to ID.
- `pc_IFID`  out  WIDTH  address of `instruction_IFID`.
- `pc_4_IFID`  out  WIDTH  `pc_IFID + 4`.
- `valid_IFID`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- Accept: `imem_req && imem_ready`. On accept, PC <= PC+4 (mod 2^WIDTH, wraps silently). `outstanding` += 1; decremented on each `imem_rvalid`.
- `imem_req` = reset deasserted && `outstanding + fifo_count < DEPTH`. It is independent of `stall`; credits alone prevent overflow.
- `resp_pc` tracks the address of the next expected response. It is set to `RESET_PC`/`redirect_pc` on reset/redirect and incremented by 4 on each kept response.
- `drop_cnt`: response with `drop_cnt>0` is discarded and `drop_cnt` decremented. Kept responses push {rdata, resp_pc} into the fetch FIFO.
- IF/ID update, priority highest first:
  1. `flush`: load NOP (32'h0000_0013), pc/pc_4 = 0, valid=0. Flush beats stall.
  2. `stall`: hold all four outputs.
  3. FIFO non-empty: pop head into IF/ID, valid=1.
  4. FIFO empty and a kept response arrives this cycle: bypass it directly into IF/ID, valid=1.
  5. Otherwise: load bubble (NOP, valid=0).
- Redirect (`redirect_en=1`):
  - PC <= `redirect_pc`; a request accepted in the same cycle is still counted but is dropped.
  - `drop_cnt` <= `outstanding` after this cycle's accept/response updates.
  - A response arriving this cycle is dropped.
  - FIFO is cleared.
  - A redirect while `drop_cnt>0` reloads `drop_cnt` with the current outstanding count.
- `redirect_en` does not itself touch IF/ID; EX asserts `flush` with it.
- Misaligned `redirect_pc` (bits [1:0]≠0) is fetched as-is; no exception is generated.

## Timing
- Reset values:
  - `instruction_IFID`=32'h0000_0013; `pc_IFID`=0; `pc_4_IFID`=0; `valid_IFID`=0.
  - `imem_req`=0; `imem_addr`=`RESET_PC`.
  - `outstanding`, `drop_cnt`, FIFO all 0.
- First `imem_req` is in the first cycle with `reset==1`.
- With a 1-cycle memory: accept in cycle n → `imem_rvalid` in n+1 → IF/ID valid from n+2 (bypass path).
- Redirect in cycle r with a 1-cycle memory: the first target request is issued in r+1, and its word reaches IF/ID at r+3.
- A kept response is never lost during `stall`; the FIFO absorbs it.
- `reset` low mid-operation discards everything; responses to pre-reset requests must not arrive after reset (memory is reset together).

## Configuration
- `IF_FETCH_BUFFER_EN` defined: DEPTH = `MAX_OUTSTANDING`. With a 1-cycle memory, sustains one instruction per cycle.
- Undefined: DEPTH = 1. Only one request is in flight or buffered at a time, giving at most one instruction every 2 cycles. All other behaviour is identical.

## Structure
- Shared package `if_pkg`: `NOP_INST` (32'h0000_0013), default `RESET_PC`, typedef `fetch_entry_t` {instruction, pc}.
- Reuse `inst_defs.sv` range macros.
- Sub-module `fetch_fifo`: parameterised-depth synchronous FIFO of `fetch_entry_t` with push/pop/clear and count. The `clear` input is driven by redirect.

## Test plan
- Reset then straight-line fetch, 1-cycle memory returning word = addr, buffer on: `pc_IFID` = 0,4,8,… one per cycle from cycle 2, `valid_IFID`=1, `pc_4_IFID`=`pc_IFID`+4.
- `stall` high for 3 cycles mid-stream: IF/ID frozen. FIFO fills to 2, `imem_req` drops. After release, no address is skipped or duplicated.
- `redirect_en`+`flush` to 0x100 with 2 requests outstanding:
  - Next IF/ID is a bubble (0x13, valid=0).
  - Both stale responses are dropped.
  - The first valid `pc_IFID`=0x100.
- `flush` and `stall` in the same cycle: IF/ID becomes NOP/valid=0.
- `imem_ready` low for 4 cycles and response latency 3: ordering is preserved and `outstanding` never exceeds DEPTH. Macro off: at most 1 in flight, half throughput.
- Assert `reset`=0 mid-stream: next cycle all outputs are at their reset values; the first fetch after release is at `RESET_PC`.

Source files
------------

// File: rtl/if_pkg.sv
// Fetch-stage shared types and constants: NOP encoding, default reset PC,
// and the {instruction, pc} entry carried through the fetch buffer.
package if_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Bits needed to hold a count of 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; head is visible combinationally, push/pop take effect at the edge.
// Push is ignored when full unless a pop frees the slot the same cycle; clear beats push and pop.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = cnt_width(DEPTH),
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/inst_defs.sv
// Shared bit-range helpers used in bus declarations across the fetch stage.
// Include-guarded so every file can pull it in regardless of compile order.
`ifndef INST_DEFS_SV
`define INST_DEFS_SV
`define RANGE(w) (w)-1:0
`define WORD_RANGE [31:0]
`endif

// File: rtl/instruction_fetch_pipe.sv
// IF stage: PC, in-order imem requests, fetch buffer, IF/ID register; 1-cycle memory gives IF/ID two cycles after accept.
// Credits (outstanding + buffered < depth) throttle imem_req; IF_FETCH_BUFFER_EN sets depth to MAX_OUTSTANDING, else 1.
`ifndef INST_DEFS_SV
`include "inst_defs.sv"
`endif

module instruction_fetch_pipe
  import if_pkg::*;
#(
  parameter int unsigned      WIDTH           = 32,
  parameter logic [WIDTH-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int unsigned      MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect_en,
  input  logic [`RANGE(WIDTH)] redirect_pc,
  output logic                 imem_req,
  output logic [`RANGE(WIDTH)] imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [`RANGE(WIDTH)] imem_rdata,
  output logic [`RANGE(WIDTH)] instruction_IFID,
  output logic [`RANGE(WIDTH)] pc_IFID,
  output logic [`RANGE(WIDTH)] pc_4_IFID,
  output logic                 valid_IFID
);

`ifdef IF_FETCH_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  localparam int unsigned DEPTH   = BUF_EN ? MAX_OUTSTANDING : 1;
  localparam int unsigned CW      = cnt_width(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [`RANGE(WIDTH)] pc_q, pc_d;
  logic [`RANGE(WIDTH)] resp_pc_q, resp_pc_d;
  logic [CW-1:0]        outst_q, outst_d;
  logic [CW-1:0]        drop_q, drop_d;
  logic [`RANGE(WIDTH)] instr_q, instr_d;
  logic [`RANGE(WIDTH)] ifid_pc_q, ifid_pc_d;
  logic [`RANGE(WIDTH)] ifid_pc4_q, ifid_pc4_d;
  logic                 valid_q, valid_d;

  logic                 accept;
  logic                 rsp_keep;
  logic                 bypass;
  logic [CW:0]          credits_used;
  logic                 fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]        fifo_count;
  fetch_entry_t         fifo_head, push_entry;

  assign credits_used = {1'b0, outst_q} + {1'b0, fifo_count};
  assign imem_req     = reset && (credits_used < DEPTH_C);
  assign imem_addr    = pc_q;
  assign accept       = imem_req && imem_ready;

  // Anything arriving in a redirect cycle or while stale fetches drain is discarded.
  assign rsp_keep   = imem_rvalid && !redirect_en && (drop_q == '0);
  assign bypass     = rsp_keep && fifo_empty && !flush && !stall;
  assign fifo_push  = rsp_keep && !bypass;
  assign fifo_pop   = !flush && !stall && !fifo_empty;
  assign push_entry = '{instruction: imem_rdata, pc: resp_pc_q};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_en),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q;
    drop_d    = drop_q;

    if (accept)      outst_d = outst_d + CW'(1);
    if (imem_rvalid) outst_d = outst_d - CW'(1);

    if (imem_rvalid && !redirect_en && (drop_q != '0)) drop_d = drop_q - CW'(1);

    if (redirect_en) begin
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
      drop_d    = outst_d;
    end else begin
      if (accept)   pc_d      = pc_q + WIDTH'(4);
      if (rsp_keep) resp_pc_d = resp_pc_q + WIDTH'(4);
    end
  end

  always_comb begin
    instr_d    = WIDTH'(NOP_INST);
    ifid_pc_d  = '0;
    ifid_pc4_d = '0;
    valid_d    = 1'b0;
    if (flush) begin
      valid_d = 1'b0;
    end else if (stall) begin
      instr_d    = instr_q;
      ifid_pc_d  = ifid_pc_q;
      ifid_pc4_d = ifid_pc4_q;
      valid_d    = valid_q;
    end else if (!fifo_empty) begin
      instr_d    = fifo_head.instruction;
      ifid_pc_d  = fifo_head.pc;
      ifid_pc4_d = fifo_head.pc + WIDTH'(4);
      valid_d    = 1'b1;
    end else if (rsp_keep) begin
      instr_d    = imem_rdata;
      ifid_pc_d  = resp_pc_q;
      ifid_pc4_d = resp_pc_q + WIDTH'(4);
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      instr_q    <= WIDTH'(NOP_INST);
      ifid_pc_q  <= '0;
      ifid_pc4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      instr_q    <= instr_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_pc4_q <= ifid_pc4_d;
      valid_q    <= valid_d;
    end
  end

  assign instruction_IFID = instr_q;
  assign pc_IFID          = ifid_pc_q;
  assign pc_4_IFID        = ifid_pc4_q;
  assign valid_IFID       = valid_q;

endmodule

// File: tb/tb_instruction_fetch_pipe.sv
// Directed bench for instruction_fetch_pipe with a queue-based memory returning word = address.
module tb_instruction_fetch_pipe;

  localparam logic [31:0] RPC = 32'h0000_0040;
`ifdef IF_FETCH_BUFFER_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction_IFID;
  logic [31:0] pc_IFID;
  logic [31:0] pc_4_IFID;
  logic        valid_IFID;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       q[$];
  int          slot = 0;
  int          mem_lat = 1;
  logic        mem_rdy = 1'b1;
  logic        rv_drv = 1'b0;
  logic [31:0] exp_pc = RPC;
  logic [31:0] snap_i = 32'h0, snap_pc = 32'h0, snap_pc4 = 32'h0;
  logic        snap_v = 1'b0;

  instruction_fetch_pipe #(
    .WIDTH           (32),
    .RESET_PC        (RPC),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .redirect_en      (redirect_en),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .instruction_IFID (instruction_IFID),
    .pc_IFID          (pc_IFID),
    .pc_4_IFID        (pc_4_IFID),
    .valid_IFID       (valid_IFID)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory: one response per cycle, in order, mem_lat cycles after acceptance.
  always @(posedge clk) begin
    #4;
    slot++;
    if (rv_drv) q.delete(0);
    imem_ready = mem_rdy;
    if (!reset) begin
      q.delete();
      imem_rvalid = 1'b0;
      rv_drv      = 1'b0;
    end else begin
      chk("outstanding_le_depth", 32'(q.size() <= DEPTH), 32'd1);
      imem_rvalid = (q.size() > 0) && (q[0].due <= slot);
      imem_rdata  = (q.size() > 0) ? q[0].addr : 32'hDEAD_BEEF;
      rv_drv      = imem_rvalid;
      if (imem_req && imem_ready) q.push_back('{imem_addr, slot + mem_lat});
    end
  end

  // One clock; afterwards checks in-order delivery or hold, depending on what was driven.
  task automatic tick();
    logic ps = stall;
    logic pf = flush;
    logic pr = reset;
    @(posedge clk);
    #3;
    if (pr && !pf) begin
      if (ps) begin
        chk("stall_hold_instr", instruction_IFID, snap_i);
        chk("stall_hold_pc", pc_IFID, snap_pc);
        chk("stall_hold_pc4", pc_4_IFID, snap_pc4);
        chk("stall_hold_valid", 32'(valid_IFID), 32'(snap_v));
      end else if (valid_IFID) begin
        chk("order_pc", pc_IFID, exp_pc);
        chk("order_instr", instruction_IFID, exp_pc);
        chk("order_pc4", pc_4_IFID, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end
    end
    snap_i   = instruction_IFID;
    snap_pc  = pc_IFID;
    snap_pc4 = pc_4_IFID;
    snap_v   = valid_IFID;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid_IFID && n < 12) begin
      tick();
      n++;
    end
    chk(tag, 32'(valid_IFID), 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_instr"}, instruction_IFID, 32'h0000_0013);
    chk({tag, "_pc"}, pc_IFID, 32'h0);
    chk({tag, "_pc4"}, pc_4_IFID, 32'h0);
    chk({tag, "_valid"}, 32'(valid_IFID), 32'd0);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, RPC);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_instr"}, instruction_IFID, 32'h0000_0013);
    chk({tag, "_valid"}, 32'(valid_IFID), 32'd0);
    chk({tag, "_pc"}, pc_IFID, 32'h0);
    chk({tag, "_pc4"}, pc_4_IFID, 32'h0);
  endtask

  initial begin
    int nv;
    int w;

    repeat (3) tick();
    chk_reset_state("reset");

    // Release reset: request issued in the very first cycle.
    reset  = 1'b1;
    exp_pc = RPC;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RPC);
    tick();
    chk("first_not_yet_valid", 32'(valid_IFID), 32'd0);
    tick();
    chk("first_valid", 32'(valid_IFID), 32'd1);
    chk("first_pc", pc_IFID, RPC);

    nv = 0;
    repeat (8) begin
      tick();
      nv += int'(valid_IFID);
    end
    chk("throughput_8cyc", 32'(nv), 32'((DEPTH == 2) ? 8 : 4));

    // Stall three cycles: buffer fills and requests stop.
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    chk("stall_req_dropped", 32'(imem_req), 32'd0);
    chk("stall_still_valid", 32'(valid_IFID), 32'd1);
    repeat (6) tick();

    // Redirect with flush to 0x100.
    redirect_en = 1'b1;
    flush       = 1'b1;
    redirect_pc = 32'h0000_0100;
    exp_pc      = 32'h0000_0100;
    tick();
    redirect_en = 1'b0;
    flush       = 1'b0;
    chk_bubble("redir_bubble");
    w = 0;
    while (!valid_IFID && w < 12) begin
      tick();
      w++;
    end
    chk("redir_valid", 32'(valid_IFID), 32'd1);
    chk("redir_first_pc", pc_IFID, 32'h0000_0100);
`ifdef IF_FETCH_BUFFER_EN
    chk("redir_latency", 32'(w), 32'd2);
`endif
    repeat (4) tick();

    // Flush and stall together: flush wins.
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    chk_bubble("flush_over_stall");
    repeat (4) tick();

    // Misaligned target near the top of the address space: fetched as-is, PC wraps.
    redirect_en = 1'b1;
    flush       = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    exp_pc      = 32'hFFFF_FFFE;
    tick();
    redirect_en = 1'b0;
    flush       = 1'b0;
    wait_valid("misalign_valid");
    chk("misalign_pc", pc_IFID, 32'hFFFF_FFFE);
    chk("misalign_pc4_wrap", pc_4_IFID, 32'h0000_0002);
    tick();
    wait_valid("wrap_valid");
    chk("wrap_pc", pc_IFID, 32'h0000_0002);

    // Memory not ready for 4 cycles, then latency 3.
    mem_rdy = 1'b0;
    mem_lat = 3;
    repeat (4) tick();
    chk("nrdy_req_held", 32'(imem_req), 32'd1);
    chk("nrdy_drained", 32'(valid_IFID), 32'd0);
    mem_rdy = 1'b1;
    repeat (20) tick();

    // Reset mid-stream.
    reset = 1'b0;
    tick();
    chk_reset_state("midreset");
    reset   = 1'b1;
    mem_lat = 1;
    exp_pc  = RPC;
    #1;
    chk("postreset_req", 32'(imem_req), 32'd1);
    chk("postreset_addr", imem_addr, RPC);
    wait_valid("postreset_valid");
    chk("postreset_pc", pc_IFID, RPC);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
